// File: rtl/password_lock_ctrl.sv
// Keypad password controller: collects three BCD digits, checks them against a
// stored code, and drives the seven-segment display, try counter and hold timers.
module password_lock_ctrl #(
  parameter logic [11:0] PASSWORD    = 12'h123,
  parameter int unsigned MAX_TRIES   = 6,
  parameter int unsigned PASS_CYCLES = 150_000_000,
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] data,
  output logic [3:0]  tries,
  output logic [1:0]  times,
  output logic        unlock,
  output logic        locked
);

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam logic [31:0] PASS_LAST = 32'(PASS_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);
  localparam logic [4:0]  MAX_T     = 5'(MAX_TRIES);

  state_t      state_q, state_d;
  logic [11:0] data_q, data_d;
  logic [3:0]  tries_q, tries_d;
  logic [1:0]  times_q, times_d;
  logic        unlock_q, unlock_d;
  logic        locked_q, locked_d;
  logic [31:0] timer_q, timer_d;

  logic       is_digit, is_clear, is_enter;
  logic [4:0] tries_inc;

  assign is_digit  = key_valid && (key_code <= 4'h9);
  assign is_clear  = key_valid && (key_code == 4'hE);
  assign is_enter  = key_valid && (key_code == 4'hF);
  // One bit wider so the lockout compare cannot wrap when MAX_TRIES is 15.
  assign tries_inc = {1'b0, tries_q} + 5'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ENTRY;
      data_q   <= 12'h000;
      tries_q  <= 4'd0;
      times_q  <= 2'd0;
      unlock_q <= 1'b0;
      locked_q <= 1'b0;
      timer_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      tries_q  <= tries_d;
      times_q  <= times_d;
      unlock_q <= unlock_d;
      locked_q <= locked_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    tries_d  = tries_q;
    times_d  = times_q;
    unlock_d = unlock_q;
    locked_d = locked_q;
    timer_d  = timer_q;

    case (state_q)
      ENTRY: begin
        if (is_digit) begin
          if (times_q != 2'd3) begin
            data_d  = {data_q[7:0], key_code};
            times_d = times_q + 2'd1;
          end
        end else if (is_clear) begin
          data_d  = 12'h000;
          times_d = 2'd0;
        end else if (is_enter && (times_q == 2'd3)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (data_q == PASSWORD) begin
          state_d  = PASS;
          data_d   = 12'hBCC;
          unlock_d = 1'b1;
          timer_d  = 32'd0;
        end else if (tries_inc >= MAX_T) begin
          state_d  = LOCK;
          tries_d  = tries_inc[3:0];
          data_d   = 12'hDDD;
          times_d  = 2'd0;
          locked_d = 1'b1;
          timer_d  = 32'd0;
        end else begin
          state_d = ENTRY;
          tries_d = tries_inc[3:0];
          data_d  = 12'h000;
          times_d = 2'd0;
        end
      end

      PASS: begin
        timer_d = timer_q + 32'd1;
        // A clear key ends the hold early exactly as the timeout does.
        if ((timer_q == PASS_LAST) || is_clear) begin
          state_d  = ENTRY;
          data_d   = 12'h000;
          times_d  = 2'd0;
          tries_d  = 4'd0;
          unlock_d = 1'b0;
          timer_d  = 32'd0;
        end
      end

      LOCK: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == LOCK_LAST) begin
          state_d  = ENTRY;
          tries_d  = 4'd0;
          data_d   = 12'h000;
          locked_d = 1'b0;
          timer_d  = 32'd0;
        end
      end

      default: state_d = ENTRY;
    endcase
  end

  assign data   = data_q;
  assign tries  = tries_q;
  assign times  = times_q;
  assign unlock = unlock_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Directed bench for password_lock_ctrl with short PASS/LOCK hold times.
module tb_password_lock_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [11:0] data;
  logic [3:0]  tries;
  logic [1:0]  times;
  logic        unlock;
  logic        locked;

  int total = 0;
  int bad   = 0;

  password_lock_ctrl #(
    .PASSWORD   (12'h123),
    .MAX_TRIES  (6),
    .PASS_CYCLES(8),
    .LOCK_CYCLES(16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .key_valid(key_valid),
    .key_code (key_code),
    .data     (data),
    .tries    (tries),
    .times    (times),
    .unlock   (unlock),
    .locked   (locked)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic press(input logic [3:0] code);
    @(negedge CLK);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge CLK);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wrong_attempt();
    press(4'h4); press(4'h5); press(4'h6); press(4'hF);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h7;
    repeat (2) @(negedge CLK);
    total++; if (data !== 12'h000) begin bad++; $display("[TB] FAIL reset_data: got %h want %h", data, 12'h000); end
    total++; if (times !== 2'd0) begin bad++; $display("[TB] FAIL reset_times: got %0d want 0", times); end
    total++; if ({tries, unlock, locked} !== 6'd0) begin bad++; $display("[TB] FAIL reset_flags: tries=%0d unlock=%b locked=%b want 0/0/0", tries, unlock, locked); end
    key_valid = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_pass();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    total++; if (data !== 12'h123) begin bad++; $display("[TB] FAIL entry_data: got %h want 123", data); end
    total++; if (times !== 2'd3) begin bad++; $display("[TB] FAIL entry_times: got %0d want 3", times); end
    press(4'hF);
    total++; if (unlock !== 1'b0) begin bad++; $display("[TB] FAIL check_cycle_unlock: got %b want 0", unlock); end
    @(negedge CLK);
    total++; if (data !== 12'hBCC) begin bad++; $display("[TB] FAIL pass_data: got %h want bcc", data); end
    total++; if (unlock !== 1'b1 || tries !== 4'd0) begin bad++; $display("[TB] FAIL pass_flags: unlock=%b tries=%0d want 1/0", unlock, tries); end
    repeat (7) @(negedge CLK);
    total++; if (unlock !== 1'b1) begin bad++; $display("[TB] FAIL pass_last_cycle: unlock=%b want 1", unlock); end
    @(negedge CLK);
    total++; if (unlock !== 1'b0 || data !== 12'h000 || times !== 2'd0) begin bad++; $display("[TB] FAIL pass_timeout: unlock=%b data=%h times=%0d want 0/000/0", unlock, data, times); end
  endtask

  task automatic test_wrong();
    wrong_attempt();
    total++; if (tries !== 4'd1) begin bad++; $display("[TB] FAIL wrong_tries: got %0d want 1", tries); end
    total++; if (data !== 12'h000 || times !== 2'd0 || unlock !== 1'b0) begin bad++; $display("[TB] FAIL wrong_outputs: data=%h times=%0d unlock=%b want 000/0/0", data, times, unlock); end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int i = 0; i < 5; i++) wrong_attempt();
    total++; if (tries !== 4'd5 || locked !== 1'b0) begin bad++; $display("[TB] FAIL five_wrong: tries=%0d locked=%b want 5/0", tries, locked); end
    wrong_attempt();
    total++; if (locked !== 1'b1 || data !== 12'hDDD || tries !== 4'd6) begin bad++; $display("[TB] FAIL lock_enter: locked=%b data=%h tries=%0d want 1/ddd/6", locked, data, tries); end
    press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    total++; if (data !== 12'hDDD || times !== 2'd0 || locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_keys: data=%h times=%0d locked=%b want ddd/0/1", data, times, locked); end
    repeat (7) @(negedge CLK);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_last_cycle: locked=%b want 1", locked); end
    @(negedge CLK);
    total++; if (locked !== 1'b0 || tries !== 4'd0 || data !== 12'h000) begin bad++; $display("[TB] FAIL lock_timeout: locked=%b tries=%0d data=%h want 0/0/000", locked, tries, data); end
  endtask

  task automatic test_clear_and_ignored();
    press(4'h7); press(4'h8);
    total++; if (data !== 12'h078 || times !== 2'd2) begin bad++; $display("[TB] FAIL two_keys: data=%h times=%0d want 078/2", data, times); end
    press(4'hE);
    total++; if (data !== 12'h000 || times !== 2'd0) begin bad++; $display("[TB] FAIL clear: data=%h times=%0d want 000/0", data, times); end
    press(4'h7); press(4'hF);
    @(negedge CLK);
    total++; if (times !== 2'd1 || tries !== 4'd0 || data !== 12'h007) begin bad++; $display("[TB] FAIL short_enter: times=%0d tries=%0d data=%h want 1/0/007", times, tries, data); end
    press(4'hB);
    total++; if (data !== 12'h007 || times !== 2'd1) begin bad++; $display("[TB] FAIL key_b: data=%h times=%0d want 007/1", data, times); end
  endtask

  task automatic test_reset_mid_timer();
    do_reset();
    press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++; if ({data, tries, times, unlock, locked} !== 20'd0) begin bad++; $display("[TB] FAIL reset_mid_pass: data=%h tries=%0d times=%0d unlock=%b locked=%b want all 0", data, tries, times, unlock, locked); end
    for (int i = 0; i < 6; i++) wrong_attempt();
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++; if ({data, tries, times, unlock, locked} !== 20'd0) begin bad++; $display("[TB] FAIL reset_mid_lock: data=%h tries=%0d times=%0d unlock=%b locked=%b want all 0", data, tries, times, unlock, locked); end
    press(4'h1);
    total++; if (data !== 12'h001 || times !== 2'd1) begin bad++; $display("[TB] FAIL entry_after_reset: data=%h times=%0d want 001/1", data, times); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wrong_attempt();
    press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    @(negedge CLK);
    total++; if (unlock !== 1'b1 || tries !== 4'd1) begin bad++; $display("[TB] FAIL pass_keeps_tries: unlock=%b tries=%0d want 1/1", unlock, tries); end
    @(negedge CLK);
    press(4'hE);
    total++; if (unlock !== 1'b0 || tries !== 4'd0 || data !== 12'h000 || times !== 2'd0) begin bad++; $display("[TB] FAIL pass_clear: unlock=%b tries=%0d data=%h times=%0d want 0/0/000/0", unlock, tries, data, times); end
    press(4'h4); press(4'h5); press(4'h6);
    @(negedge CLK);
    key_valid = 1'b1;
    key_code  = 4'hF;
    @(negedge CLK);
    key_code  = 4'h1;
    @(negedge CLK);
    key_valid = 1'b0;
    total++; if (times !== 2'd0 || data !== 12'h000 || tries !== 4'd1) begin bad++; $display("[TB] FAIL check_drop: times=%0d data=%h tries=%0d want 0/000/1", times, data, tries); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_wrong();
    test_lockout();
    test_clear_and_ignored();
    test_reset_mid_timer();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/password_lock_ctrl.md
# password_lock_ctrl

Keypad-driven controller that sequences the 4-digit seven-segment password display. It collects three decimal digits, compares them against a stored code, and counts failed attempts. It drives the display's `data`, `tries` and `times` inputs, including the `12'hBCC` "PASS" pattern and the `12'hDDD` dash pattern. It also runs the unlock-hold and lockout timers.

## Interface
- `PASSWORD`, 12'h123, three BCD digits (each 0–9); most significant digit is the first digit entered.
- `MAX_TRIES`, 6, failed attempts that trigger lockout (1–15).
- `PASS_CYCLES`, 150_000_000, cycles PASS is held (3 s at 50 MHz).
- `LOCK_CYCLES`, 500_000_000, cycles LOCK is held (10 s at 50 MHz).
- `CLK`  input  1  system clock, 50 MHz.
- `RST`  input  1  synchronous, active-high reset.
- `key_valid`  input  1  one-cycle strobe; `key_code` is valid in that cycle.
- `key_code`  input  4  4'h0–4'h9 digit, 4'hE clear, 4'hF enter; 4'hA–4'hD are ignored.
- `data`  output  12  digits to display, or the PASS / dash pattern.
- `tries`  output  4  failed-attempt count.
- `times`  output  2  number of digits entered so far (0–3).
- `unlock`  output  1  high while in PASS.
- `locked`  output  1  high while in LOCK.

## Operation
- All outputs are registered.
- Reset values: state ENTRY, `data`=12'h000, `tries`=0, `times`=0, `unlock`=0, `locked`=0, timer=0.
- Timer width is 32 bits.
- Keys are acted on only when `key_valid`=1.

States and transitions:
- ENTRY, digit key, `times`<3:
  - `data` <= {data[7:0], key_code}.
  - `times` <= `times`+1.
- ENTRY, digit key, `times`==3: ignored.
- ENTRY, clear (4'hE): `data`<=0, `times`<=0, `tries` unchanged.
- ENTRY, enter (4'hF):
  - `times`==3: go to CHECK.
  - `times`<3: ignored, no try consumed.
- CHECK (exactly 1 cycle; keys ignored):
  - `data`==`PASSWORD`: go to PASS. `data`<=12'hBCC, `unlock`<=1, timer<=0, `tries` unchanged.
  - Mismatch and `tries`+1 ≥ `MAX_TRIES`: go to LOCK. `tries`<=`tries`+1, `data`<=12'hDDD, `times`<=0, `locked`<=1, timer<=0.
  - Mismatch otherwise: go to ENTRY. `tries`<=`tries`+1, `data`<=0, `times`<=0.
- PASS:
  - Timer increments each cycle.
  - When timer==`PASS_CYCLES`-1, or on a clear key: go to ENTRY. `data`<=0, `times`<=0, `tries`<=0, `unlock`<=0.
  - All other keys are ignored.
- LOCK:
  - Every key is ignored.
  - When timer==`LOCK_CYCLES`-1: go to ENTRY. `tries`<=0, `data`<=0, `locked`<=0.
- `tries` never exceeds `MAX_TRIES`, so no wrap-around is possible.
- `RST` in any state, including mid-timer, forces the reset values on the next edge.

## Timing
- A key strobed at edge N is reflected in `data`/`times` after edge N.
- Enter accepted at edge N: state is CHECK after N; the result (`data`, `tries`, `unlock`, `locked`) is visible after edge N+1.
- PASS lasts exactly `PASS_CYCLES` cycles from the first cycle `unlock`=1. LOCK likewise lasts `LOCK_CYCLES` cycles.
- `key_valid` coinciding with `RST`: reset wins.
- `key_valid` coinciding with the CHECK cycle: dropped.
- `key_valid` coinciding with the final timer cycle: dropped, except clear in PASS, which has the same effect as the timeout.

## Test plan
- Overrides for all scenarios: `PASS_CYCLES`=8, `LOCK_CYCLES`=16.
- Reset; keys 1,2,3,4 → `data`=12'h123, `times`=3 (4 ignored). Enter → two edges later `data`=12'hBCC, `unlock`=1, `tries`=0. After 8 cycles: `data`=0, `unlock`=0.
- Keys 4,5,6, enter → `tries`=1, `data`=0, `times`=0, `unlock`=0.
- Six wrong attempts → `locked`=1, `data`=12'hDDD, `tries`=6. Keys 1,2,3,enter during LOCK have no effect. After 16 cycles: `locked`=0, `tries`=0, `data`=0.
- Keys 7,8, then 4'hE → `data`=0, `times`=0. Enter with `times`=1 is ignored and `tries` is unchanged. Key 4'hB is ignored.
- `RST` asserted mid-PASS (timer=3) and, separately, mid-LOCK → all outputs at reset values after the next edge.
- In PASS, clear at cycle 2 → ENTRY next edge with `tries`=0. A key strobed during the CHECK cycle is dropped (`times` stays 0).
